// File: rtl/de_selector14_pkg.sv
// de_selector14_pkg: shared channel count, index type and arbiter state encoding.
package de_selector14_pkg;
  localparam int NCH = 4;
  typedef logic [1:0] chanIdx;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SETUP = 2'd1;
  localparam logic [1:0] ACTIVE = 2'd2;
  localparam logic [1:0] RELEASE = 2'd3;
endpackage

// File: rtl/de_selector14.sv
// de_selector14: 1-to-4 demultiplexer routing iC to the output chosen by {iS1,iS0}.
module de_selector14 (
  input  logic iC,
  input  logic iS1,
  input  logic iS0,
  output logic oZ0,
  output logic oZ1,
  output logic oZ2,
  output logic oZ3
);
  assign oZ0 = iC & ~iS1 & ~iS0;
  assign oZ1 = iC & ~iS1 & iS0;
  assign oZ2 = iC & iS1 & ~iS0;
  assign oZ3 = iC & iS1 & iS0;
endmodule

// File: rtl/de_selector14_arbiter_rr_pick4.sv
// rr_pick4: first requesting channel scanning from iPtr upward with 2-bit wrap.
module rr_pick4
  import de_selector14_pkg::*;
(
  input  logic [NCH-1:0] iReq,
  input  chanIdx         iPtr,
  output chanIdx         oIdx,
  output logic           oValid
);
  logic [NCH-1:0] rot;
  chanIdx off;
  always_comb begin
    rot = '0;
    for (int i = 0; i < NCH; i++) rot[i] = iReq[iPtr + chanIdx'(i)];
    off = rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3;
  end
  assign oIdx = iPtr + off;
  assign oValid = |iReq;
endmodule

// File: rtl/de_selector14_arbiter.sv
// de_selector14_arbiter: round-robin grant of the 1-to-4 demux with a bounded dwell window.
module de_selector14_arbiter
  import de_selector14_pkg::*;
#(
  parameter int HOLD_CYCLES = 4
) (
  input  logic           iClk,
  input  logic           iRst,
  input  logic [NCH-1:0] iReq,
  input  logic [NCH-1:0] iDone,
  input  logic           iData,
  output logic           oS1,
  output logic           oS0,
  output logic           oC,
  output logic [NCH-1:0] oGnt,
  output logic           oBusy
);
  localparam int CW = $clog2(HOLD_CYCLES + 1);
  logic [1:0] state;
  chanIdx ptr, pick, gIdx;
  logic pickValid, done;
  logic [CW-1:0] cnt;
  rr_pick4 picker (.iReq(iReq), .iPtr(ptr), .oIdx(pick), .oValid(pickValid));
  // select lines only move on SETUP entry, so they hold the locked grant index
  assign gIdx = {oS1, oS0};
  assign done = cnt == CW'(HOLD_CYCLES - 1) || iDone[gIdx] || !iReq[gIdx];
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state <= IDLE;
      {oS1, oS0} <= 2'b00;
      oC <= 1'b0;
      oGnt <= '0;
      oBusy <= 1'b0;
      ptr <= 2'd0;
      cnt <= '0;
    end else begin
      case (state)
        IDLE: if (pickValid) begin
          state <= SETUP;
          {oS1, oS0} <= pick;
          oGnt <= 4'b1 << pick;
          oBusy <= 1'b1;
        end
        SETUP: begin
          state <= ACTIVE;
          cnt <= '0;
        end
        ACTIVE: begin
          cnt <= done ? cnt : cnt + 1'b1;
          oC <= done ? 1'b0 : iData;
          if (done) begin
            state <= RELEASE;
            oGnt <= '0;
            ptr <= gIdx + 2'd1;
          end
        end
        RELEASE: begin
          state <= IDLE;
          oBusy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_de_selector14_arbiter.sv
// tb_de_selector14_arbiter: directed grant episodes checked by a scoreboard monitor.
module tb_de_selector14_arbiter;
  typedef struct {
    int inst;
    int chan;
    int gntLen;
    int busyLen;
    logic [15:0] oc;
    int gap;
  } epRec;
  logic iClk = 0, iRst = 1, iData = 0;
  logic [3:0] iReq = 0, iDone = 0, iReq1 = 0, iDone1 = 0;
  logic [1:0] s1, s0, c, busy;
  logic [3:0] gnt [2];
  logic z0, z1, z2, z3;
  int passCnt = 0, totalCnt = 0, cycle = 0;
  epRec q[$];
  epRec e;
  bit inEp [2];
  int lastStart [2], gntLen [2], busyLen [2], chan [2], gapV [2];
  logic [15:0] ocPat [2];
  logic [3:0] firstGnt [2];

  de_selector14_arbiter #(.HOLD_CYCLES(4)) dut0 (
    .iClk(iClk), .iRst(iRst), .iReq(iReq), .iDone(iDone), .iData(iData),
    .oS1(s1[0]), .oS0(s0[0]), .oC(c[0]), .oGnt(gnt[0]), .oBusy(busy[0])
  );
  de_selector14_arbiter #(.HOLD_CYCLES(1)) dut1 (
    .iClk(iClk), .iRst(iRst), .iReq(iReq1), .iDone(iDone1), .iData(iData),
    .oS1(s1[1]), .oS0(s0[1]), .oC(c[1]), .oGnt(gnt[1]), .oBusy(busy[1])
  );
  de_selector14 demux (
    .iC(c[0]), .iS1(s1[0]), .iS0(s0[0]), .oZ0(z0), .oZ1(z1), .oZ2(z2), .oZ3(z3)
  );

  always #5 iClk = ~iClk;

  task automatic chk(input string name, input int act, input int exp);
    totalCnt++;
    if (act == exp) passCnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge iClk);
    #1;
  endtask

  task automatic pushExp(input int inst, input int ch, input int gl, input int bl,
                         input logic [15:0] oc, input int gap);
    q.push_back('{inst, ch, gl, bl, oc, gap});
  endtask

  task automatic chkReset();
    for (int k = 0; k < 2; k++)
      chk($sformatf("reset%0d outputs", k), {gnt[k], s1[k], s0[k], c[k], busy[k]}, 0);
  endtask

  // episode = contiguous oBusy window; its shape is compared against the next queued record
  always @(negedge iClk) begin
    cycle++;
    if (c[0]) chk("demux routing", {z3, z2, z1, z0}, 1 << {s1[0], s0[0]});
    for (int k = 0; k < 2; k++) begin
      if (busy[k] && !inEp[k]) begin
        inEp[k] = 1;
        gntLen[k] = 0;
        busyLen[k] = 0;
        ocPat[k] = 0;
        chan[k] = int'({s1[k], s0[k]});
        firstGnt[k] = gnt[k];
        gapV[k] = cycle - lastStart[k];
        lastStart[k] = cycle;
      end
      if (inEp[k] && busy[k]) begin
        if (gnt[k] != 0) gntLen[k]++;
        if (busyLen[k] < 16) ocPat[k][busyLen[k]] = c[k];
        busyLen[k]++;
      end else if (inEp[k]) begin
        inEp[k] = 0;
        if (q.size() == 0) chk("unexpected episode on instance", k, -1);
        else begin
          e = q.pop_front();
          chk("episode instance", k, e.inst);
          chk($sformatf("inst%0d select", k), chan[k], e.chan);
          chk($sformatf("inst%0d first grant", k), int'(firstGnt[k]), 1 << e.chan);
          chk($sformatf("inst%0d grant length", k), gntLen[k], e.gntLen);
          chk($sformatf("inst%0d busy length", k), busyLen[k], e.busyLen);
          chk($sformatf("inst%0d oC pattern", k), int'(ocPat[k]), int'(e.oc));
          if (e.gap != 0) chk($sformatf("inst%0d grant spacing", k), gapV[k], e.gap);
        end
      end
    end
  end

  initial begin
    cyc(2);
    chkReset();
    iRst = 0;
    // single full dwell on channel 2 with a data pattern; exit edge forces oC low
    pushExp(0, 2, 5, 6, 16'h0014, 0);
    iReq = 4'b0100; iData = 1;
    cyc(3);
    iData = 0;
    cyc(1);
    iData = 1;
    cyc(2);
    iReq = 0; iData = 0;
    cyc(3);
    // all requesting from ptr=0: 0,1,2,3,0 spaced 7 cycles
    iRst = 1;
    cyc(1);
    chkReset();
    iRst = 0;
    pushExp(0, 0, 5, 6, 16'h0, 0);
    for (int i = 1; i < 5; i++) pushExp(0, i % 4, 5, 6, 16'h0, 7);
    iReq = 4'b1111;
    cyc(34);
    iReq = 0;
    cyc(3);
    // early release of channel 2 in its 2nd ACTIVE cycle, then channel 3 follows
    pushExp(0, 2, 3, 4, 16'h0004, 0);
    pushExp(0, 3, 5, 6, 16'h001C, 5);
    iData = 1; iReq = 4'b0100;
    cyc(3);
    iDone = 4'b0100; iReq = 4'b1111;
    cyc(1);
    iDone = 0;
    cyc(7);
    iReq = 0;
    cyc(3);
    // locked grant on channel 1 ignores new request bits and a foreign done
    pushExp(0, 1, 5, 6, 16'h001C, 0);
    pushExp(0, 0, 5, 6, 16'h001C, 7);
    iReq = 4'b0010;
    cyc(3);
    iReq = 4'b0011; iDone = 4'b0001;
    cyc(1);
    iDone = 0;
    cyc(9);
    iReq = 0;
    cyc(3);
    // reset mid-ACTIVE drops grant and ptr; 1001 then picks 0 (stale ptr=1 would pick 3)
    pushExp(0, 2, 3, 3, 16'h0004, 0);
    pushExp(0, 0, 5, 6, 16'h001C, 4);
    iReq = 4'b0100;
    cyc(3);
    iRst = 1;
    cyc(1);
    chkReset();
    iRst = 0; iReq = 4'b1001;
    cyc(6);
    iReq = 0;
    cyc(3);
    // HOLD_CYCLES=1: one ACTIVE cycle whose exit edge zeroes oC
    pushExp(1, 0, 2, 3, 16'h0, 0);
    iReq1 = 4'b0001;
    cyc(3);
    iReq1 = 0;
    cyc(4);
    chk("scoreboard drained", q.size(), 0);
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end
endmodule
